jtbubl_pal_sched: RTL and testbench
===================================

// Module: jtbubl_pal_sched
// PURPOSE
//  Write scheduler for the two byte-lane palette RAMs (even/odd, 256 entries each).
//  Queues CPU palette writes in a small FIFO and commits them to the RAM write port
//  only in allowed slots (blanking, or any cycle). Runs a clear engine that zeroes
//  all 512 palette bytes after reset or on request.
//  Sits between the CPU bus decode and the palette RAM port 0 in the colour mixer.
// PARAMETERS
//  FIFO_AW  2  log2 of write FIFO depth (default depth 4)
//  ANYTIME  0  0: commit only while ~LHBL|~LVBL; 1: commit in any cycle
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  LHBL       in   1  horizontal blank, active low
//  LVBL       in   1  vertical blank, active low
//  pal_cs     in   1  CPU palette chip select
//  cpu_rnw    in   1  CPU read(1)/write(0)
//  cpu_addr   in   9  CPU byte address; bit0 selects odd lane
//  cpu_dout   in   8  CPU write data
//  cpu_wait   out  1  stall CPU: write pending and FIFO full
//  clr_req    in   1  pulse: start full palette clear
//  clr_busy   out  1  clear engine running
//  ram_addr   out  8  palette RAM port-0 address
//  ram_din    out  8  palette RAM port-0 write data
//  ram_we0    out  1  even-lane write enable
//  ram_we1    out  1  odd-lane write enable
//  pal_even   in   8  even-lane read data (port 0)
//  pal_odd    in   8  odd-lane read data (port 0)
//  pal_dout   out  8  CPU read data
// BEHAVIOUR
//  - Reset (rst=1): FIFO emptied, ram_we0/1=0, ram_addr=0, ram_din=0, cpu_wait=0,
//    clr_busy=1; state=CLEAR, clear counter=0. Clear starts the cycle rst falls.
//  - States: CLEAR, RUN. CLEAR: each clk writes 0 to both lanes (we0=we1=1) at
//    ram_addr=counter; counter 0..255, then RUN, clr_busy=0 next cycle. 256 cycles.
//    No commit gating during CLEAR (blanking ignored).
//  - clr_req in RUN -> CLEAR, counter=0. clr_req in CLEAR restarts counter at 0.
//  - Push: one entry {addr[8:0],data} per CPU write access, on rising edge of
//    (pal_cs & ~cpu_rnw). Held access while FIFO full: cpu_wait=1 (combinational),
//    entry pushed on first cycle with space; never dropped, never duplicated.
//  - Pushes accepted in both states; FIFO commits only in RUN.
//  - Commit (RUN): FIFO non-empty and (ANYTIME | ~LHBL | ~LVBL) -> pop one entry per
//    clk; registered outputs: ram_addr=addr[8:1], ram_din=data, ram_we0=~addr[0],
//    ram_we1=addr[0]; strobes high exactly one cycle. Latency push->we >= 1 cycle.
//  - Full FIFO with simultaneous pop and push: both happen; count unchanged;
//    cpu_wait=0 that cycle.
//  - FIFO pointers wrap modulo depth; order strictly FIFO (last write wins in RAM).
//  - Blank closing mid-drain: remaining entries wait for next blank.
//  - pal_dout = cpu_addr[0] ? pal_odd : pal_even (one-cycle RAM read latency).
// CONFIGURATION
//  JTBUBL_PAL_FWD_EN defined: CPU read of a byte address matching a queued entry
//   returns the newest matching entry's data (search newest to oldest), else RAM.
//  Not defined: pal_dout is always raw RAM data; queued writes invisible until
//   committed.
// TESTING
//  1 Reset then idle 256 clk -> we0=we1=1 for addrs 0..255 in order, clr_busy
//    falls at cycle 257; palette model all zero.
//  2 ANYTIME=0, LHBL=LVBL=1, write 0x5A to 0x013 -> no strobe; LHBL=0 -> next
//    clk ram_we1=1, ram_addr=0x09, ram_din=0x5A, one cycle.
//  3 Five writes in active video with depth 4 -> cpu_wait=1 on 5th; on blank,
//    wait drops after first pop, all five commit in order.
//  4 clr_req at counter=100 with 2 queued writes -> counter restarts 0, full 256
//    zero writes, then the 2 queued writes commit (final RAM holds them).
//  5 JTBUBL_PAL_FWD_EN: write 0x11 then 0x22 to 0x040 in active video, read 0x040
//    -> 0x22; without macro -> old RAM value.
//  6 rst pulsed mid-drain with 3 entries -> FIFO empty, no further CPU writes
//    committed, clear restarts at addr 0.

Source files
------------

// File: rtl/jtbubl_pal_sched.sv
// -----------------------------------------------------------------------------
// jtbubl_pal_sched
//   Write scheduler for the two byte-lane palette RAMs (even/odd lanes,
//   256 entries each). CPU palette writes are queued in a small FIFO and
//   committed to RAM port 0 only in allowed slots (blanking, or any cycle when
//   ANYTIME=1). A clear engine zeroes all 512 palette bytes after reset or on
//   request.
//
// Parameters
//   FIFO_AW   log2 of write FIFO depth
//   ANYTIME   0: commit only while ~LHBL | ~LVBL, 1: commit in any cycle
//
// Optional feature (compile-time macro JTBUBL_PAL_FWD_EN)
//   Defined    : CPU reads of a byte address that matches a queued entry
//                return the newest matching entry's data.
//   Not defined: pal_dout is always raw RAM data.
//
// Ports
//   clk        system clock, all logic on rising edge
//   rst        synchronous active-high reset
//   LHBL/LVBL  horizontal / vertical blank, active low
//   pal_cs     CPU palette chip select
//   cpu_rnw    CPU read(1) / write(0)
//   cpu_addr   CPU byte address, bit 0 selects the odd lane
//   cpu_dout   CPU write data
//   cpu_wait   stall: write pending while the FIFO is full
//   clr_req    pulse: start a full palette clear
//   clr_busy   clear engine running
//   ram_addr   palette RAM port-0 address (registered)
//   ram_din    palette RAM port-0 write data (registered)
//   ram_we0    even-lane write enable (registered)
//   ram_we1    odd-lane write enable (registered)
//   pal_even   even-lane read data
//   pal_odd    odd-lane read data
//   pal_dout   CPU read data
// -----------------------------------------------------------------------------
module jtbubl_pal_sched #(
    parameter int FIFO_AW = 2,
    parameter bit ANYTIME = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic       pal_cs,
    input  logic       cpu_rnw,
    input  logic [8:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic       cpu_wait,
    input  logic       clr_req,
    output logic       clr_busy,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_din,
    output logic       ram_we0,
    output logic       ram_we1,
    input  logic [7:0] pal_even,
    input  logic [7:0] pal_odd,
    output logic [7:0] pal_dout
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } entry_t;

    state_t             state;
    state_t             state_nx;
    logic [7:0]         clr_cnt;

    entry_t             fifo_mem [DEPTH];
    entry_t             head;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    logic               empty;
    logic               full;
    logic               slot_ok;
    logic               wr_acc;
    logic               wr_done;
    logic               pending;
    logic               push;
    logic               pop;
    logic [7:0]         ram_rdata;

    // -------------------------------------------------------------------------
    // FIFO handshake and commit slot decision
    // -------------------------------------------------------------------------
    // NOTE: every signal driven from always_comb receives a default at the top
    // of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        empty   = (count == '0);
        full    = (count == (FIFO_AW+1)'(DEPTH));
        slot_ok = ANYTIME | ~LHBL | ~LVBL;
        head    = fifo_mem[rd_ptr];

        // A held write access counts once: wr_done marks it as already queued
        // until pal_cs/cpu_rnw release the access.
        wr_acc  = pal_cs & ~cpu_rnw;
        pending = wr_acc & ~wr_done;

        // A clear request takes the port, so no commit happens that cycle.
        pop      = ~rst & (state == ST_RUN) & ~clr_req & ~empty & slot_ok;
        // A full FIFO still accepts a push when an entry leaves the same cycle.
        push     = ~rst & pending & (~full | pop);
        cpu_wait = ~rst & pending & full & ~pop;
    end

    // -------------------------------------------------------------------------
    // State machine: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR: if (!clr_req && clr_cnt == 8'hFF) state_nx = ST_RUN;
            ST_RUN:   if (clr_req) state_nx = ST_CLEAR;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register, clear counter, FIFO pointers and RAM port outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_cnt  <= 8'd0;
            clr_busy <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_done  <= 1'b0;
            ram_addr <= 8'd0;
            ram_din  <= 8'd0;
            ram_we0  <= 1'b0;
            ram_we1  <= 1'b0;
        end else begin
            state    <= state_nx;
            // Stays high through the last clear write, drops one cycle later.
            clr_busy <= (state == ST_CLEAR) | (state_nx == ST_CLEAR);

            wr_done  <= wr_acc & (wr_done | push);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};

            // Between writes the port address follows the CPU, so a read sees
            // the addressed word one cycle later.
            ram_we0  <= 1'b0;
            ram_we1  <= 1'b0;
            ram_addr <= cpu_addr[8:1];

            if (clr_req) begin
                clr_cnt <= 8'd0;
            end else if (state == ST_CLEAR) begin
                ram_addr <= clr_cnt;
                ram_din  <= 8'd0;
                ram_we0  <= 1'b1;
                ram_we1  <= 1'b1;
                clr_cnt  <= clr_cnt + 8'd1;
            end else if (pop) begin
                ram_addr <= head.addr[8:1];
                ram_din  <= head.data;
                ram_we0  <= ~head.addr[0];
                ram_we1  <= head.addr[0];
            end
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count alone decide
    // which words are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: cpu_addr, data: cpu_dout};
    end

    // -------------------------------------------------------------------------
    // CPU read path
    // -------------------------------------------------------------------------
    assign ram_rdata = cpu_addr[0] ? pal_odd : pal_even;

`ifdef JTBUBL_PAL_FWD_EN
    logic       fwd_hit;
    logic [7:0] fwd_data;

    // Walk from oldest to newest; a later match overrides an earlier one, so
    // the newest queued write to the address wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((FIFO_AW+1)'(i) < count &&
                fifo_mem[rd_ptr + FIFO_AW'(i)].addr == cpu_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_mem[rd_ptr + FIFO_AW'(i)].data;
            end
        end
    end

    assign pal_dout = fwd_hit ? fwd_data : ram_rdata;
`else
    assign pal_dout = ram_rdata;
`endif

endmodule

// File: tb/tb_jtbubl_pal_sched.sv
// -----------------------------------------------------------------------------
// tb_jtbubl_pal_sched
//   Self-checking bench for jtbubl_pal_sched (FIFO_AW=2, ANYTIME=0).
//   Holds a two-lane palette RAM model (one-cycle read latency), a log of
//   single-lane commits seen on the port, and a palette image model built
//   from the CPU writes issued in order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtbubl_pal_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       LHBL, LVBL;
    logic       pal_cs, cpu_rnw;
    logic [8:0] cpu_addr;
    logic [7:0] cpu_dout;
    logic       cpu_wait;
    logic       clr_req;
    logic       clr_busy;
    logic [7:0] ram_addr, ram_din;
    logic       ram_we0, ram_we1;
    logic [7:0] pal_even, pal_odd;
    logic [7:0] pal_dout;

    int checks = 0;
    int errors = 0;

    jtbubl_pal_sched dut (
        .clk      (clk),
        .rst      (rst),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .pal_cs   (pal_cs),
        .cpu_rnw  (cpu_rnw),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_wait (cpu_wait),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we0  (ram_we0),
        .ram_we1  (ram_we1),
        .pal_even (pal_even),
        .pal_odd  (pal_odd),
        .pal_dout (pal_dout)
    );

    always #5 clk = ~clk;

    // ---------------- palette RAM model and commit monitor ----------------
    logic [7:0]  mem_e [256];
    logic [7:0]  mem_o [256];
    logic [16:0] commit_q [$];   // {byte address, data}
    logic [16:0] issued_q [$];
    logic [7:0]  exp_pal [512];
    logic        blank_prev = 1'b0;
    int          gate_viol = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_e[i] = 8'hFF;
            mem_o[i] = 8'hFF;
        end
    end

    always @(posedge clk) begin
        if (ram_we0) mem_e[ram_addr] <= ram_din;
        if (ram_we1) mem_o[ram_addr] <= ram_din;
        pal_even <= mem_e[ram_addr];
        pal_odd  <= mem_o[ram_addr];
        if (ram_we0 ^ ram_we1) begin
            commit_q.push_back({ram_addr, ram_we1, ram_din});
            // The strobe was produced at the previous edge; blanking must
            // have been active then.
            if (!blank_prev) gate_viol <= gate_viol + 1;
        end
        blank_prev <= ~LHBL | ~LVBL;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU write access; the access is held while cpu_wait is high.
    task automatic cpu_write(input logic [8:0] addr, input logic [7:0] data);
        int waited = 0;
        pal_cs   = 1'b1;
        cpu_rnw  = 1'b0;
        cpu_addr = addr;
        cpu_dout = data;
        issued_q.push_back({addr, data});
        exp_pal[addr] = data;
        #1;
        while (cpu_wait && waited < 200) begin
            if (waited >= 8) LHBL = 1'b0;   // open a blank so the FIFO drains
            tick();
            waited++;
        end
        if (waited >= 200) check("cpu_wait_timeout", 32'(waited), 0);
        tick();
        pal_cs  = 1'b0;
        cpu_rnw = 1'b1;
        tick();
    endtask

    // Waits until the commit log holds n entries (bounded).
    task automatic wait_commits(input int n, input string name);
        int b = 0;
        while (commit_q.size() < n && b < 100) begin
            tick();
            b++;
        end
        check(name, 32'(commit_q.size()), 32'(n));
    endtask

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
        logic       lhbl;
        logic       lvbl;
        logic       exp_we0;
        logic       exp_we1;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int bad;
        int b;
        int n;
        logic [16:0] e;

        rst = 1'b1; LHBL = 1'b1; LVBL = 1'b1;
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_dout = '0; clr_req = 1'b0;
        for (int i = 0; i < 512; i++) exp_pal[i] = 8'h00;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_we0",      32'(ram_we0),  0);
        check("rst_we1",      32'(ram_we1),  0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_din",  32'(ram_din),  0);
        check("rst_cpu_wait", 32'(cpu_wait), 0);
        check("rst_clr_busy", 32'(clr_busy), 1);

        // ---------------- power-up clear ----------------
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (!(ram_we0 && ram_we1 && ram_addr == 8'(k) && ram_din == 8'd0)) bad++;
            if (k == 255) check("clr_busy_last_write", 32'(clr_busy), 1);
        end
        check("clear_sequence_bad", 32'(bad), 0);
        tick();
        check("clr_busy_fall", 32'(clr_busy), 0);
        check("no_strobe_after_clear", 32'(ram_we0 | ram_we1), 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem_e[i] != 0 || mem_o[i] != 0) bad++;
        check("palette_zero", 32'(bad), 0);

        // ---------------- single write commit table ----------------
        vecs[0] = '{9'h013, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h09};
        vecs[1] = '{9'h0A2, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h51};
        vecs[2] = '{9'h1FF, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[3] = '{9'h000, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        for (int v = 0; v < 4; v++) begin
            LHBL = 1'b1; LVBL = 1'b1;
            cpu_write(vecs[v].addr, vecs[v].data);
            bad = 0;
            repeat (3) begin
                tick();
                if (ram_we0 || ram_we1) bad++;
            end
            check($sformatf("vec%0d_no_strobe_active", v), 32'(bad), 0);
            LHBL = vecs[v].lhbl; LVBL = vecs[v].lvbl;
            tick();
            check($sformatf("vec%0d_we0", v),  32'(ram_we0),  32'(vecs[v].exp_we0));
            check($sformatf("vec%0d_we1", v),  32'(ram_we1),  32'(vecs[v].exp_we1));
            check($sformatf("vec%0d_addr", v), 32'(ram_addr), 32'(vecs[v].exp_addr));
            check($sformatf("vec%0d_din", v),  32'(ram_din),  32'(vecs[v].data));
            tick();
            check($sformatf("vec%0d_one_cycle", v), 32'(ram_we0 | ram_we1), 0);
        end
        LHBL = 1'b1; LVBL = 1'b1;
        tick();

        // ---------------- FIFO full, stall, drain in order ----------------
        commit_q.delete();
        for (int i = 0; i < 4; i++) cpu_write(9'h020 + 9'(i), 8'h10 + 8'(i));
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 9'h024; cpu_dout = 8'h14;
        exp_pal[9'h024] = 8'h14;
        #1;
        check("full_wait_high", 32'(cpu_wait), 1);
        repeat (3) tick();
        check("full_wait_held", 32'(cpu_wait), 1);
        LHBL = 1'b0;
        #1;
        check("wait_drops_with_pop", 32'(cpu_wait), 0);
        tick();
        pal_cs = 1'b0; cpu_rnw = 1'b1;
        wait_commits(5, "five_commits");
        bad = 0;
        for (int i = 0; i < 5 && i < commit_q.size(); i++)
            if (commit_q[i] != {9'h020 + 9'(i), 8'h10 + 8'(i)}) bad++;
        check("five_commits_order", 32'(bad), 0);
        repeat (3) tick();
        check("no_duplicate_commit", 32'(commit_q.size()), 5);
        LHBL = 1'b1;
        tick();

        // ---------------- clear restart with queued writes ----------------
        commit_q.delete();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_req_busy", 32'(clr_busy), 1);
        cpu_write(9'h0C4, 8'hA5);
        cpu_write(9'h0C5, 8'h3C);
        exp_pal[9'h0C4] = 8'hA5;
        exp_pal[9'h0C5] = 8'h3C;
        LHBL = 1'b0;   // blanking must not let commits through during clear
        b = 0;
        while (!(ram_we0 && ram_we1 && ram_addr == 8'd99) && b < 300) begin
            tick();
            b++;
        end
        check("reach_counter_100", 32'(b < 300), 1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        check("restart_addr0_we", 32'(ram_we0 & ram_we1), 1);
        check("restart_addr0",    32'(ram_addr), 0);
        bad = 0;
        for (int k = 1; k < 256; k++) begin
            tick();
            if (!(ram_we0 && ram_we1 && ram_addr == 8'(k))) bad++;
        end
        check("restart_full_clear", 32'(bad), 0);
        check("no_commit_during_clear", 32'(commit_q.size()), 0);
        wait_commits(2, "queued_after_clear");
        check("ram_after_clear_c4", 32'(mem_e[8'h62]), 32'h0A5);
        check("ram_after_clear_c5", 32'(mem_o[8'h62]), 32'h03C);

        // ---------------- read forwarding ----------------
        LHBL = 1'b1; LVBL = 1'b1;
        tick();
        cpu_write(9'h040, 8'h11);
        cpu_write(9'h040, 8'h22);
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 9'h040;
        tick();
        tick();
`ifdef JTBUBL_PAL_FWD_EN
        check("read_queued_040", 32'(pal_dout), 32'h22);
`else
        check("read_queued_040", 32'(pal_dout), 32'h00);
`endif
        LHBL = 1'b0;
        repeat (6) tick();
        check("read_committed_040", 32'(pal_dout), 32'h22);
        pal_cs = 1'b0;
        LHBL = 1'b1;
        tick();

        // ---------------- reset mid-drain ----------------
        cpu_write(9'h101, 8'hAA);
        cpu_write(9'h102, 8'hBB);
        cpu_write(9'h103, 8'hCC);
        LHBL = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("midrst_we", 32'(ram_we0 | ram_we1), 0);
        check("midrst_busy", 32'(clr_busy), 1);
        commit_q.delete();
        rst = 1'b0;
        tick();
        check("midrst_clear_addr0", 32'({ram_we0, ram_we1, ram_addr}), 32'h300);
        repeat (300) tick();
        check("midrst_no_commit", 32'(commit_q.size()), 0);
        check("midrst_ram_zero", 32'(mem_o[8'h80] | mem_e[8'h81] | mem_o[8'h81]), 0);
        for (int i = 0; i < 512; i++) exp_pal[i] = 8'h00;

        // ---------------- randomized writes vs palette model ----------------
        commit_q.delete();
        issued_q.delete();
        gate_viol = 0;
        for (int i = 0; i < 150; i++) begin
            LHBL = ($urandom_range(0, 3) != 0);
            LVBL = ($urandom_range(0, 7) != 0);
            cpu_write(9'($urandom_range(0, 47)), 8'($urandom));
            n = $urandom_range(0, 2);
            repeat (n) tick();
        end
        LHBL = 1'b0;
        wait_commits(issued_q.size(), "rand_commit_count");
        bad = 0;
        for (int i = 0; i < issued_q.size() && i < commit_q.size(); i++)
            if (commit_q[i] != issued_q[i]) bad++;
        check("rand_commit_order", 32'(bad), 0);
        tick();
        bad = 0;
        for (int a = 0; a < 512; a++) begin
            e[7:0] = a[0] ? mem_o[a >> 1] : mem_e[a >> 1];
            if (e[7:0] != exp_pal[a]) bad++;
        end
        check("rand_palette_image", 32'(bad), 0);
        check("rand_commit_outside_blank", 32'(gate_viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
